mfp_pmod_als_light_monitor: RTL
===============================

// Module: mfp_pmod_als_light_monitor
// PURPOSE
//  Consumes the free-running 16-bit PmodALS SPI frame register and turns it into light data:
//  it samples the frame periodically, checks its format and extracts the 8-bit ADC code.
//  It also keeps an exponential moving average, min/max and a sample count.
//  A hysteretic dark/bright FSM raises a sticky interrupt for the MIPSfpga system IRQ/GPIO logic.
// PARAMETERS
//  SAMPLE_PERIOD  512  cycles between samples; >=2; 512 = one full SPI frame cycle
//  AVG_LOG2       3    EMA weight 1/2^AVG_LOG2; legal range 0..4 (0 = no filtering)
// PORTS
//  clock       in   1   system clock
//  reset_n     in   1   reset; asynchronous, active-low
//  value       in   16  latest SPI frame, held stable between frames
//  thr_lo      in   8   enter-DARK threshold (avg < thr_lo)
//  thr_hi      in   8   enter-BRIGHT threshold (avg > thr_hi)
//  clear       in   1   1-cycle pulse: clear irq, frame_err, sample_cnt, min/max
//  light       out  8   last valid raw code, value[12:5]
//  light_avg   out  8   EMA of light
//  light_min   out  8   minimum valid code since reset/clear
//  light_max   out  8   maximum valid code since reset/clear
//  sample_cnt  out  16  valid samples since reset/clear, saturates at 16'hFFFF
//  dark        out  1   1 = FSM in DARK
//  frame_err   out  1   sticky: a sample had value[15:13] != 0
//  irq         out  1   sticky level: DARK<->BRIGHT transition occurred
// BEHAVIOUR
//  Reset: every output is 0; tick counter = 0; acc = 0; FSM = INIT; seeded = 0.
//  Tick: counter runs 0..SAMPLE_PERIOD-1 and wraps. tick = 1 when counter == SAMPLE_PERIOD-1.
//    The first tick occurs SAMPLE_PERIOD cycles after reset release.
//  On tick, if value[15:13] == 0 the sample is valid (raw = value[12:5]). Registered at that edge:
//    light <= raw; sample_cnt +1 (saturating).
//    acc (8+AVG_LOG2 bits): first valid sample after reset: acc <= raw << AVG_LOG2.
//      Afterwards: acc <= acc - (acc >> AVG_LOG2) + raw. No overflow is possible.
//    light_avg = acc >> AVG_LOG2 (registered, same edge as acc).
//    min/max: if !seeded, min = max = raw and seeded <= 1; else min/max update.
//  On tick with value[15:13] != 0: frame_err <= 1; light, acc, min, max and cnt are unchanged;
//    no FSM evaluation is done.
//  FSM evaluation happens in the cycle after a valid tick (eval pulse, using the new light_avg).
//    dark and irq change one edge later, i.e. 2 cycles after the tick edge.
//    INIT  : avg < thr_lo -> DARK, else -> BRIGHT. irq is not set.
//    BRIGHT: avg < thr_lo -> DARK, irq <= 1.
//    DARK  : avg > thr_hi -> BRIGHT, irq <= 1.
//    Comparisons are unsigned and strict. At most one transition per eval.
//    If thr_lo > thr_hi the FSM may toggle on every sample; this is legal and is not guarded.
//  dark = (state == DARK); INIT and BRIGHT both give dark = 0.
//  clear effects:
//    irq <= 0, frame_err <= 0, sample_cnt <= 0, seeded <= 0.
//    acc, light_avg, light and FSM state are untouched.
//  Simultaneous events:
//    clear with an irq-setting eval: irq = 1 (no event is lost).
//    clear with a valid tick: sample_cnt = 1, min = max = raw, seeded = 1.
//    clear with an invalid tick: frame_err = 1.
//  Reset mid-operation returns everything to reset values immediately (async). The counter restarts.
//  thr_lo/thr_hi are sampled only at eval; changing them has no effect until the next sample.
// TESTING
//  Reset release, value = 16'h0C80 -> all outputs 0 until cycle 512; then light = avg = min = max = 100.
//    Also cnt = 1, dark = 0, irq = 0.
//  AVG_LOG2 = 3, thr_lo = 50, thr_hi = 80; after 100 seed apply value = 16'h0140 (raw 10).
//    -> avg sequence 88, 79, 70, 62, 56, 50, 45.
//    -> dark = 1 and irq = 1 two cycles after the 7th tick; min = 10, max = 100.
//  In DARK, value = 16'h1FE0 (raw 255) -> dark = 0 on the first tick with avg > 80; irq stays 1.
//  value = 16'hE000 -> frame_err = 1; light/avg/cnt/min/max unchanged; dark unchanged.
//  clear pulsed in the same cycle as an irq-setting eval -> irq = 1. Clear alone -> irq = 0, cnt = 0.
//  Assert reset_n = 0 mid-period, release -> next tick exactly 512 cycles later; FSM back in INIT.
//    Expect no irq on the first sample.

Source files
------------

// File: rtl/mfp_pmod_als_light_monitor.sv
// PmodALS light monitor: periodically samples the SPI frame register, validates it, and tracks
// the EMA, min/max and sample count, plus a hysteretic dark/bright FSM with a sticky interrupt.
module mfp_pmod_als_light_monitor #(
  parameter int SAMPLE_PERIOD = 512,
  parameter int AVG_LOG2      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [7:0]  thr_lo,
  input  logic [7:0]  thr_hi,
  input  logic        clear,
  output logic [7:0]  light,
  output logic [7:0]  light_avg,
  output logic [7:0]  light_min,
  output logic [7:0]  light_max,
  output logic [15:0] sample_cnt,
  output logic        dark,
  output logic        frame_err,
  output logic        irq
);
  // state     | meaning
  // ST_INIT   | no sample evaluated since reset; first eval picks DARK/BRIGHT silently
  // ST_BRIGHT | light above the dark threshold; falling below thr_lo raises irq
  // ST_DARK   | light below thr_lo; rising above thr_hi raises irq
  typedef enum logic [1:0] {ST_INIT, ST_BRIGHT, ST_DARK} state_t;

  localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int AW = 8 + AVG_LOG2;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          sample_ok;
  logic          sample_bad;
  logic [7:0]    raw;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic          acc_seeded;
  logic          seeded;
  logic          eval;
  logic          irq_set;
  state_t        state;
  state_t        state_next;

  assign tick       = (tick_cnt == CW'(SAMPLE_PERIOD - 1));
  assign raw        = value[12:5];
  assign sample_ok  = tick && (value[15:13] == 3'b000);
  assign sample_bad = tick && (value[15:13] != 3'b000);
  assign dark       = (state == ST_DARK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // acc holds avg scaled by 2^AVG_LOG2, so the subtract/add keeps it within 255 << AVG_LOG2
  always_comb begin
    acc_next = acc;
    if (!acc_seeded) acc_next = AW'(raw) << AVG_LOG2;
    else             acc_next = acc - (acc >> AVG_LOG2) + AW'(raw);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      acc_seeded <= 1'b0;
      light      <= '0;
      light_avg  <= '0;
      light_min  <= '0;
      light_max  <= '0;
      sample_cnt <= '0;
      seeded     <= 1'b0;
      frame_err  <= 1'b0;
      eval       <= 1'b0;
    end else begin
      eval <= sample_ok;
      if (sample_ok) begin
        acc        <= acc_next;
        acc_seeded <= 1'b1;
        light      <= raw;
        light_avg  <= 8'(acc_next >> AVG_LOG2);
        if (clear)                     sample_cnt <= 16'd1;
        else if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
        if (!seeded || clear) begin
          light_min <= raw;
          light_max <= raw;
          seeded    <= 1'b1;
        end else begin
          if (raw < light_min) light_min <= raw;
          if (raw > light_max) light_max <= raw;
        end
      end else if (clear) begin
        sample_cnt <= '0;
        light_min  <= '0;
        light_max  <= '0;
        seeded     <= 1'b0;
      end
      if (sample_bad)  frame_err <= 1'b1;
      else if (clear)  frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      irq   <= 1'b0;
    end else begin
      state <= state_next;
      if (irq_set)    irq <= 1'b1;
      else if (clear) irq <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    irq_set    = 1'b0;
    if (eval) begin
      case (state)
        ST_INIT:   state_next = (light_avg < thr_lo) ? ST_DARK : ST_BRIGHT;
        ST_BRIGHT: if (light_avg < thr_lo) begin
                     state_next = ST_DARK;
                     irq_set    = 1'b1;
                   end
        ST_DARK:   if (light_avg > thr_hi) begin
                     state_next = ST_BRIGHT;
                     irq_set    = 1'b1;
                   end
        default:   state_next = ST_INIT;
      endcase
    end
  end
endmodule
